// File: rtl/badd16_mw_seq.sv
// ============================================================================
// Module   : badd16_mw_seq (with helper badd16)
// Brief    : Multi-word adder sequencer sharing one 16-bit Brent-Kung adder
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module badd16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [16:0] sum
);

  logic [15:0] w_prop0;
  logic [15:0] w_gen;

  assign w_prop0 = a ^ b;

  // In-place prefix tree: within one level, every updated bit only reads bits
  // that this level leaves untouched, so sequential updates are safe.
  always_comb begin
    logic [15:0] g;
    logic [15:0] p;
    int          j;
    g = a & b;
    p = a ^ b;
    j = 0;
    for (int l = 0; l < 4; l++) begin
      for (int i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          j = i - (1 << l);
          g[4'(i)] = g[4'(i)] | (p[4'(i)] & g[4'(j)]);
          p[4'(i)] = p[4'(i)] & p[4'(j)];
        end
      end
    end
    for (int l = 2; l >= 0; l--) begin
      for (int i = 0; i < 16; i++) begin
        if ((i >= (3 * (1 << l)) - 1) && (((i + 1 - (1 << l)) % (2 << l)) == 0)) begin
          j = i - (1 << l);
          g[4'(i)] = g[4'(i)] | (p[4'(i)] & g[4'(j)]);
        end
      end
    end
    w_gen = g;
  end

  assign sum = {w_gen[15], w_prop0 ^ {w_gen[14:0], 1'b0}};

endmodule

module badd16_mw_seq #(
  parameter int NWORDS = 4,
  parameter int IDXW   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [16*NWORDS-1:0]  op_a,
  input  logic [16*NWORDS-1:0]  op_b,
  output logic                  busy,
  output logic                  done,
  output logic [16*NWORDS:0]    result
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_CINC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               r_state;
  logic [16*NWORDS-1:0] r_a;
  logic [16*NWORDS-1:0] r_b;
  logic [IDXW-1:0]      r_idx;
  logic                 r_carry;
  logic                 r_c1;
  logic [15:0]          r_partial;

  logic [15:0]          w_add_a;
  logic [15:0]          w_add_b;
  logic [16:0]          w_sum;

  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    case (r_state)
      S_ADD: begin
        for (int k = 0; k < NWORDS; k++) begin
          if (r_idx == IDXW'(k)) begin
            w_add_a = r_a[16*k +: 16];
            w_add_b = r_b[16*k +: 16];
          end
        end
      end
      S_CINC: begin
        w_add_a = r_partial;
        w_add_b = {15'b0, r_carry};
      end
      default: ;
    endcase
  end

  badd16 u_badd16 (
    .a   (w_add_a),
    .b   (w_add_b),
    .sum (w_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_c1      <= 1'b0;
      r_partial <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_idx   <= '0;
            r_carry <= 1'b0;
            result  <= '0;
            busy    <= 1'b1;
            r_state <= S_ADD;
          end else begin
            busy    <= 1'b0;
          end
        end
        S_ADD: begin
          r_partial <= w_sum[15:0];
          r_c1      <= w_sum[16];
          r_state   <= S_CINC;
        end
        S_CINC: begin
          for (int k = 0; k < NWORDS; k++) begin
            if (r_idx == IDXW'(k)) begin
              result[16*k +: 16] <= w_sum[15:0];
            end
          end
          // Only one of the two carries can be set; OR keeps the form obvious.
          r_carry <= r_c1 | w_sum[16];
          if (r_idx == IDXW'(NWORDS - 1)) begin
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + IDXW'(1);
            r_state <= S_ADD;
          end
        end
        S_DONE: begin
          result[16*NWORDS] <= r_carry;
          done              <= 1'b1;
          r_state           <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_badd16_mw_seq.sv
// ============================================================================
// Module   : tb_badd16_mw_seq
// Brief    : Directed self-checking bench for badd16_mw_seq (NWORDS=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_badd16_mw_seq;

  localparam int NW = 4;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [63:0]     op_a;
  logic [63:0]     op_b;
  logic            busy;
  logic            done;
  logic [64:0]     result;

  int n_checks;
  int n_errors;

  badd16_mw_seq #(.NWORDS(NW), .IDXW(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One full operation; also checks partial word writes, operand capture and
  // (optionally) that start pulses during busy are ignored.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [64:0] exp, input bit pulse_busy);
    int         cyc;
    int         extra;
    bit         got;
    logic [64:0] mask;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      start = pulse_busy && (cyc >= 3) && (cyc <= 5);
      if (cyc == 1) begin
        check({tag, "_busy"}, busy, 1);
        op_a = ~a;
        op_b = a ^ b;
      end
      for (int k = 0; k < NW; k++) begin
        if (cyc == 3 + 2 * k) begin
          mask = (65'd1 << (16 * (k + 1))) - 65'd1;
          check($sformatf("%s_w%0d", tag, k), result, exp & mask);
        end
      end
      if (done) got = 1'b1;
    end
    start = 1'b0;
    check({tag, "_done"}, got, 1);
    check({tag, "_lat"}, cyc, 2 * NW + 2);
    check({tag, "_res"}, result, exp);
    check({tag, "_busy_at_done"}, busy, 1);
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) extra++;
    end
    check({tag, "_extra_done"}, extra, 0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_hold"}, result, exp);
  endtask

  task automatic reset_mid(input string tag, input int at_cyc);
    int extra;
    @(negedge clk);
    op_a = 64'h0001_0002_0003_0004; op_b = 64'h0010_0020_0030_0040; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (at_cyc - 1) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res"}, result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check({tag, "_quiet"}, extra, 0);
  endtask

  initial begin
    int          cyc;
    bit          got;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("basic", 64'h0000_0000_0000_0001, 64'h0000_0000_0000_0002, 65'h0_0000_0000_0000_0003, 1'b0);
    do_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h1_0000_0000_0000_0000, 1'b0);
    do_op("max", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 65'h1_FFFF_FFFF_FFFF_FFFE, 1'b0);
    do_op("mixed", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 65'h0_2222_2222_2222_2211, 1'b0);
    do_op("altcarry", 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 65'h0_0001_0000_0001_0000, 1'b1);
    do_op("words", 64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 65'h0_0011_0022_0033_0044, 1'b1);

    // Back-to-back: start held high through done.
    @(negedge clk);
    op_a = 64'h8000_0000_0000_0000; op_b = 64'h8000_0000_0000_0001; start = 1'b1;
    cyc = 0; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check("b2b1_done", got, 1);
    check("b2b1_lat", cyc, 2 * NW + 2);
    check("b2b1_res", result, 65'h1_0000_0000_0000_0001);
    op_a = 64'h0000_0000_FFFF_0000; op_b = 64'h0000_0000_0001_0000;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b2_busy", busy, 1);
    check("b2b2_done_low", done, 0);
    check("b2b2_cleared", result, 0);
    cyc = 1; got = 1'b0;
    while (cyc < 40 && !got) begin
      @(posedge clk); #1;
      cyc++;
      if (done) got = 1'b1;
    end
    check("b2b2_done", got, 1);
    check("b2b2_lat", cyc, 2 * NW + 2);
    check("b2b2_res", result, 65'h0_0000_0001_0000_0000);
    repeat (3) @(posedge clk);

    reset_mid("rst_add", 1);
    reset_mid("rst_cinc", 6);
    do_op("post_rst", 64'h7FFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 65'h0_8000_0000_0000_0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
